// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix multiplier's C readout path.
package matrix_pkg;

  localparam int DATA_W = 19;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int ADDR_W = 6;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} readerState_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              last;
  } streamElem_t;

  localparam int ELEM_W = $bits(streamElem_t);

  // Row/col tags are the row-major address bits themselves.
  function automatic streamElem_t makeElem(input logic [DATA_W-1:0] data,
                                           input logic [ADDR_W-1:0] addr);
    streamElem_t elem;
    elem.data = data;
    elem.row  = addr[ADDR_W-1 -: ROW_W];
    elem.col  = addr[COL_W-1:0];
    elem.last = (addr == LAST_ADDR);
    return elem;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO with count; used by the C reader and the A/B loaders.
module stream_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wrPtr;
  logic         r_rdPtr;
  logic [1:0]   r_count;
  logic         w_doPush;
  logic         w_doPop;

  // A pop frees its slot in the same cycle, so push into a full FIFO is legal alongside a pop.
  assign w_doPop  = i_pop && (r_count != 2'd0);
  assign w_doPush = i_push && ((r_count != 2'd2) || w_doPop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_doPop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

  assert property (@(posedge clk) disable iff (reset) !(i_push && !w_doPush))
    else $error("stream_fifo2: push dropped on full FIFO");

endmodule

// File: rtl/c_matrix_reader.sv
// Drains the 8x8 C matrix from the C RAM after the multiply and streams it out
// row-major on valid/ready, tagged with row, column and last.
module c_matrix_reader
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ROW_W-1:0]  o_out_row,
  output logic [COL_W-1:0]  o_out_col,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done
);

  readerState_t      r_state;
  readerState_t      w_nextState;
  logic [ADDR_W-1:0] r_readCnt;
  logic [ADDR_W-1:0] r_lastAddr;
  logic              r_inflight;
  logic              w_issue;
  logic              w_outValid;
  logic              w_pop;
  logic              w_drainDone;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic [1:0]        w_fifoCount;
  logic [2:0]        w_slotsAfterPop;
  logic [ELEM_W-1:0] w_headBits;
  streamElem_t       w_pushElem;
  streamElem_t       w_headElem;

  assign w_outValid = !w_fifoEmpty;
  assign w_pop      = w_outValid && i_out_ready;

  // Credit: FIFO entries plus the read in flight may not exceed the two slots,
  // counting a slot freed by this cycle's pop so a steady stream runs at one per cycle.
  assign w_slotsAfterPop = {1'b0, w_fifoCount} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue         = (r_state == READ) && (w_slotsAfterPop < 3'd2);

  assign w_pushElem  = makeElem(i_ram_rd_data, r_lastAddr);
  assign w_headElem  = w_headBits;
  assign w_drainDone = w_pop && w_headElem.last && (w_fifoCount == 2'd1) && !r_inflight;

  stream_fifo2 #(
    .W (ELEM_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  (w_pushElem),
    .i_pop   (w_pop),
    .o_data  (w_headBits),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty),
    .o_count (w_fifoCount)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = READ;
      READ:    if (w_issue && (r_readCnt == LAST_ADDR)) w_nextState = DRAIN;
      DRAIN:   if (w_drainDone) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // r_lastAddr doubles as the tag of the read whose data returns next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readCnt  <= '0;
      r_lastAddr <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_lastAddr <= r_readCnt;
        if (r_readCnt != LAST_ADDR) begin
          r_readCnt <= r_readCnt + ADDR_W'(1);
        end
      end else if (r_state == IDLE) begin
        r_readCnt <= '0;
      end
    end
  end

  always_comb begin
    o_busy      = (r_state != IDLE);
    o_done      = (r_state == DRAIN) && w_drainDone;
    o_ram_addr  = w_issue ? r_readCnt : r_lastAddr;
    o_out_valid = w_outValid;
    o_out_data  = w_headElem.data;
    o_out_row   = w_headElem.row;
    o_out_col   = w_headElem.col;
    o_out_last  = w_headElem.last;
  end

  assert property (@(posedge clk) disable iff (reset) !(w_fifoFull && r_inflight && !w_pop))
    else $error("c_matrix_reader: read returned with no FIFO slot");

endmodule

// File: tb/tb_c_matrix_reader.sv
// Directed bench for c_matrix_reader: a 64-word synchronous RAM model backs the reader
// and a negedge monitor checks every beat, stall stability and the done pulse.
`timescale 1ns/1ps
module tb_c_matrix_reader;
  import matrix_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              outReady;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramRdData;
  logic              outValid;
  logic [DATA_W-1:0] outData;
  logic [ROW_W-1:0]  outRow;
  logic [COL_W-1:0]  outCol;
  logic              outLast;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] ramMem [64];
  logic [DATA_W-1:0] expMem [64];
  logic [DATA_W-1:0] seenData [64];
  logic [5:0]        seenRowCol [64];

  int cycle = 0;
  int vectorCount = 0;
  int missCount = 0;
  int expIdx = 0;
  int hsCount = 0;
  int doneCount = 0;
  int doneCycle = 0;
  int startEdge = 0;
  int releaseEdge = 0;

  logic              prevStall = 1'b0;
  logic [DATA_W-1:0] prevData;
  logic [ROW_W-1:0]  prevRow;
  logic [COL_W-1:0]  prevCol;
  logic              prevLast;

  c_matrix_reader dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (start),
    .o_ram_addr    (ramAddr),
    .i_ram_rd_data (ramRdData),
    .o_out_valid   (outValid),
    .i_out_ready   (outReady),
    .o_out_data    (outData),
    .o_out_row     (outRow),
    .o_out_col     (outCol),
    .o_out_last    (outLast),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle     <= cycle + 1;
    ramRdData <= ramMem[ramAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Beat scoreboard, stall-stability check and done bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      if (prevStall) begin
        checkOutput("stallValid", 32'(outValid), 32'd1);
        checkOutput("stallData", 32'(outData), 32'(prevData));
        checkOutput("stallRowCol", {outRow, outCol, outLast}, {prevRow, prevCol, prevLast});
      end
      if (outValid && outReady) begin
        if (expIdx < 64) begin
          checkOutput("beatData", 32'(outData), 32'(expMem[expIdx]));
          checkOutput("beatRow", 32'(outRow), 32'(expIdx / COLS));
          checkOutput("beatCol", 32'(outCol), 32'(expIdx % COLS));
          checkOutput("beatLast", 32'(outLast), 32'(expIdx == 63));
          seenData[expIdx]   = outData;
          seenRowCol[expIdx] = {outRow, outCol};
        end else begin
          checkOutput("beatIndex", 32'(expIdx), 32'd63);
        end
        expIdx++;
        hsCount++;
      end
      if (done) begin
        doneCount++;
        doneCycle = cycle;
      end
      prevStall = outValid && !outReady;
      prevData  = outData;
      prevRow   = outRow;
      prevCol   = outCol;
      prevLast  = outLast;
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic applyStimulus(input logic startIn, input logic readyIn, input logic resetIn);
    @(posedge clk);
    #1;
    start    = startIn;
    outReady = readyIn;
    reset    = resetIn;
  endtask

  task automatic waitSample();
    @(negedge clk);
    #1;
  endtask

  task automatic loadWord(input int idx, input logic [DATA_W-1:0] value);
    ramMem[idx] = value;
    expMem[idx] = value;
  endtask

  task automatic resetModel();
    expIdx    = 0;
    hsCount   = 0;
    doneCount = 0;
    doneCycle = 0;
  endtask

  task automatic pulseStart(input logic readyIn);
    applyStimulus(1'b1, readyIn, 1'b0);
    startEdge = cycle + 1;
  endtask

  task automatic runUntilDone(input int maxCycles, input int readyPct);
    for (int i = 0; i < maxCycles && doneCount == 0; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 99) < readyPct), 1'b0);
    end
  endtask

  task automatic finishReadout(input string tag);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    waitSample();
    checkOutput({tag, "Beats"}, 32'(hsCount), 32'd64);
    checkOutput({tag, "Dones"}, 32'(doneCount), 32'd1);
    checkOutput({tag, "BusyEnd"}, 32'(busy), 32'd0);
    checkOutput({tag, "ValidEnd"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    outReady = 1'b0;
    for (int i = 0; i < 64; i++) loadWord(i, DATA_W'(i * 3 - 100));

    $display("[TB] reset values");
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitSample();
    checkOutput("rstAddr", 32'(ramAddr), 32'd0);
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstData", 32'(outData), 32'd0);
    checkOutput("rstRowCol", {outRow, outCol, outLast}, 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] full readout, ready held high");
    resetModel();
    pulseStart(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitSample();
    checkOutput("busyAtStart", 32'(busy), 32'd1);
    checkOutput("validLat0", 32'(outValid), 32'd0);
    checkOutput("addrFirst", 32'(ramAddr), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitSample();
    checkOutput("validLat1", 32'(outValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitSample();
    checkOutput("validLat2", 32'(outValid), 32'd1);
    runUntilDone(200, 100);
    checkOutput("doneLatency", 32'(doneCycle - startEdge), 32'd65);
    finishReadout("full");

    $display("[TB] readout with 30%% ready");
    resetModel();
    pulseStart(1'b0);
    runUntilDone(2000, 30);
    finishReadout("random");

    $display("[TB] 20-cycle stall after start");
    resetModel();
    pulseStart(1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitSample();
      if (i == 0) checkOutput("stallAddr0", 32'(ramAddr), 32'd0);
      if (i == 1 || i == 2 || i == 19) checkOutput("stallAddrFrozen", 32'(ramAddr), 32'd1);
      if (i == 19) begin
        checkOutput("stallHeadValid", 32'(outValid), 32'd1);
        checkOutput("stallHeadData", 32'(outData), 32'(expMem[0]));
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    releaseEdge = cycle;
    runUntilDone(200, 100);
    checkOutput("noGapDrain", 32'(doneCycle - releaseEdge), 32'd63);
    finishReadout("stall");

    $display("[TB] reset after 30 handshakes");
    resetModel();
    pulseStart(1'b1);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitSample();
      if (hsCount >= 30) break;
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitSample();
    checkOutput("abortValid", 32'(outValid), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortAddr", 32'(ramAddr), 32'd0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    waitSample();
    checkOutput("abortNoDone", 32'(doneCount), 32'd0);
    checkOutput("abortBeats", 32'(hsCount), 32'd30);
    resetModel();
    pulseStart(1'b1);
    runUntilDone(200, 100);
    checkOutput("rereadLatency", 32'(doneCycle - startEdge), 32'd65);
    finishReadout("reread");

    $display("[TB] start pulses while busy, start with reset");
    resetModel();
    pulseStart(1'b1);
    for (int i = 0; i < 200 && doneCount == 0; i++) begin
      applyStimulus((i == 10 || i == 40 || i == 63), 1'b1, 1'b0);
    end
    checkOutput("busyStartLatency", 32'(doneCycle - startEdge), 32'd65);
    finishReadout("busyStart");
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitSample();
      checkOutput("rstWinsBusy", 32'(busy), 32'd0);
      checkOutput("rstWinsValid", 32'(outValid), 32'd0);
    end

    $display("[TB] corner data");
    loadWord(0, 19'h3FFFF);
    loadWord(7, 19'h40000);
    loadWord(56, 19'h00000);
    loadWord(63, 19'h7FFFF);
    resetModel();
    pulseStart(1'b1);
    runUntilDone(200, 100);
    finishReadout("corner");
    checkOutput("corner0", {seenData[0], seenRowCol[0]}, {19'h3FFFF, 6'o00});
    checkOutput("corner7", {seenData[7], seenRowCol[7]}, {19'h40000, 6'o07});
    checkOutput("corner56", {seenData[56], seenRowCol[56]}, {19'h00000, 6'o70});
    checkOutput("corner63", {seenData[63], seenRowCol[63]}, {19'h7FFFF, 6'o77});

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run did not complete, got cycle %0d, expected under 200000", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
